// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU fetch/LSU and memory-side signals of the memory arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_read_en;
    logic        d_write_en;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (
        input  if_req, if_addr, d_read_en, d_write_en, d_addr, d_size, d_wdata, mem_ready, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, d_err, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport slave (
        output if_req, if_addr, d_read_en, d_write_en, d_addr, d_size, d_wdata, mem_ready, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, d_err, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and LSU, data first
module mem_arbiter (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, DATA, FETCH, RESP_D, RESP_F} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic        d_done_q, d_done_d, f_done_q, f_done_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        d_req_any, d_pend, f_pend, misaligned, stall;
    logic [3:0]  be;
    logic [31:0] wdata, rdata_al;
    // request decode, lane steering and pipeline hold
    always_comb begin
        d_req_any  = bus.d_read_en | bus.d_write_en;
        stall      = (d_req_any & !d_done_q & !d_valid_q) | (bus.if_req & !f_done_q & !if_valid_q);
        d_pend     = d_req_any & !d_done_q;
        f_pend     = bus.if_req & !f_done_q;
        misaligned = (bus.d_size == 2'b01 & bus.d_addr[0]) | (bus.d_size[1] & |bus.d_addr[1:0]);
        be         = bus.d_size == 2'b00 ? 4'b0001 << bus.d_addr[1:0] :
                     bus.d_size == 2'b01 ? 4'b0011 << {bus.d_addr[1], 1'b0} : 4'b1111;
        wdata      = bus.d_size == 2'b00 ? {4{bus.d_wdata[7:0]}} :
                     bus.d_size == 2'b01 ? {2{bus.d_wdata[15:0]}} : bus.d_wdata;
        rdata_al   = size_q == 2'b00 ? 32'(bus.mem_rdata[{off_q, 3'b000} +: 8]) :
                     size_q == 2'b01 ? 32'(bus.mem_rdata[{off_q[1], 4'b0000} +: 16]) : bus.mem_rdata;
    end
    // next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        off_d       = off_q;
        size_d      = size_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        d_done_d    = stall ? (d_done_q | d_valid_q) : 1'b0;
        f_done_d    = stall ? (f_done_q | if_valid_q) : 1'b0;
        case (state_q)
            IDLE: begin
                if (d_pend && misaligned) begin
                    state_d   = RESP_D;
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                    d_rdata_d = '0;
                end else if (d_pend) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_write_en;
                    mem_addr_d  = bus.d_addr & 32'hFFFF_FFFC;
                    mem_be_d    = be;
                    mem_wdata_d = wdata;
                    off_d       = bus.d_addr[1:0];
                    size_d      = bus.d_size;
                end else if (f_pend) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr & 32'hFFFF_FFFC;
                    mem_be_d   = 4'b1111;
                end
            end
            DATA: begin
                if (bus.mem_ready) begin
                    state_d   = RESP_D;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    d_rdata_d = rdata_al;
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d    = RESP_F;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            f_done_q    <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
            f_done_q    <= f_done_d;
            off_q       <= off_d;
            size_q      <= size_d;
        end
    end
    assign bus.stall     = stall;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven data accesses plus fetch/priority/reset sequences
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    int fv_cnt = 0;
    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.d_valid) dv_cnt++;
        if (bus.if_valid) fv_cnt++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    typedef struct {
        logic        rd, wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata, rdata;
        logic        err;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;
    vec_t vt[10];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask
    task automatic run_vec(input int i, input vec_t v);
        @(negedge clk);
        bus.d_read_en = v.rd; bus.d_write_en = v.wr; bus.d_addr = v.addr;
        bus.d_size = v.size; bus.d_wdata = v.wdata;
        @(negedge clk);
        if (v.err) begin
            chk($sformatf("v%0d.req", i), bus.mem_req, 0);
            chk($sformatf("v%0d.we", i), bus.mem_we, 0);
            chk($sformatf("v%0d.dvalid", i), bus.d_valid, 1);
            chk($sformatf("v%0d.derr", i), bus.d_err, 1);
            chk($sformatf("v%0d.drdata", i), bus.d_rdata, 0);
            chk($sformatf("v%0d.stall", i), bus.stall, 0);
        end else begin
            chk($sformatf("v%0d.req", i), bus.mem_req, 1);
            chk($sformatf("v%0d.addr", i), bus.mem_addr, v.e_addr);
            chk($sformatf("v%0d.be", i), bus.mem_be, v.e_be);
            chk($sformatf("v%0d.wdata", i), bus.mem_wdata, v.e_wdata);
            chk($sformatf("v%0d.we", i), bus.mem_we, v.wr);
            chk($sformatf("v%0d.stall", i), bus.stall, 1);
            @(negedge clk);
            chk($sformatf("v%0d.req_hold", i), bus.mem_req, 1);
            chk($sformatf("v%0d.addr_hold", i), bus.mem_addr, v.e_addr);
            @(negedge clk);
            chk($sformatf("v%0d.dvalid_early", i), bus.d_valid, 0);
            bus.mem_ready = 1'b1; bus.mem_rdata = v.rdata;
            @(negedge clk);
            bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
            chk($sformatf("v%0d.req_off", i), bus.mem_req, 0);
            chk($sformatf("v%0d.dvalid", i), bus.d_valid, 1);
            chk($sformatf("v%0d.drdata", i), bus.d_rdata, v.e_rdata);
            chk($sformatf("v%0d.derr", i), bus.d_err, 0);
            chk($sformatf("v%0d.stall", i), bus.stall, 0);
        end
        bus.d_read_en = 1'b0; bus.d_write_en = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d.dvalid_end", i), bus.d_valid, 0);
        chk($sformatf("v%0d.req_end", i), bus.mem_req, 0);
    endtask
    initial begin
        int dv0, fv0;
        vt[0] = '{1, 0, 32'h100, 2'b10, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
        vt[1] = '{0, 1, 32'h203, 2'b00, 32'h000000A5, 32'h0,        0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vt[2] = '{1, 0, 32'h302, 2'b01, 32'h0,        32'h80011234, 0, 32'h300, 4'b1100, 32'h0,        32'h00008001};
        vt[3] = '{1, 0, 32'h101, 2'b00, 32'h0,        32'hAABBCCDD, 0, 32'h100, 4'b0010, 32'h0,        32'h000000CC};
        vt[4] = '{0, 1, 32'h010, 2'b01, 32'hFFFFBEEF, 32'h0,        0, 32'h010, 4'b0011, 32'hBEEFBEEF, 32'h0};
        vt[5] = '{0, 1, 32'h020, 2'b11, 32'h01234567, 32'h0,        0, 32'h020, 4'b1111, 32'h01234567, 32'h0};
        vt[6] = '{1, 0, 32'h003, 2'b00, 32'h0,        32'h11223344, 0, 32'h000, 4'b1000, 32'h0,        32'h00000011};
        vt[7] = '{0, 1, 32'h105, 2'b10, 32'h12345678, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vt[8] = '{1, 0, 32'h301, 2'b01, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vt[9] = '{1, 0, 32'h102, 2'b10, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0};
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_read_en = 0; bus.d_write_en = 0;
        bus.d_addr = 0; bus.d_size = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst.req", bus.mem_req, 0);
        chk("rst.we", bus.mem_we, 0);
        chk("rst.be", bus.mem_be, 0);
        chk("rst.addr", bus.mem_addr, 0);
        chk("rst.wdata", bus.mem_wdata, 0);
        chk("rst.ivalid", bus.if_valid, 0);
        chk("rst.dvalid", bus.d_valid, 0);
        chk("rst.derr", bus.d_err, 0);
        chk("rst.irdata", bus.if_rdata, 0);
        chk("rst.drdata", bus.d_rdata, 0);
        chk("rst.stall", bus.stall, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);
        // fetch alone, low address bits ignored
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 32'h47;
        @(negedge clk);
        chk("f.req", bus.mem_req, 1);
        chk("f.addr", bus.mem_addr, 32'h44);
        chk("f.be", bus.mem_be, 4'b1111);
        chk("f.we", bus.mem_we, 0);
        chk("f.stall", bus.stall, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ready = 0;
        chk("f.ivalid", bus.if_valid, 1);
        chk("f.irdata", bus.if_rdata, 32'hCAFEF00D);
        chk("f.stall", bus.stall, 0);
        bus.if_req = 0;
        @(negedge clk);
        chk("f.ivalid_end", bus.if_valid, 0);
        // simultaneous fetch and load: data first, each served once
        dv0 = dv_cnt; fv0 = fv_cnt;
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_read_en = 1; bus.d_addr = 32'h80; bus.d_size = 2'b10;
        @(negedge clk);
        chk("both.req1", bus.mem_req, 1);
        chk("both.addr1", bus.mem_addr, 32'h80);
        chk("both.stall1", bus.stall, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h11111111;
        @(negedge clk);
        bus.mem_ready = 0;
        chk("both.dvalid", bus.d_valid, 1);
        chk("both.drdata", bus.d_rdata, 32'h11111111);
        chk("both.stall2", bus.stall, 1);
        @(negedge clk);
        chk("both.gap_req", bus.mem_req, 0);
        chk("both.stall3", bus.stall, 1);
        @(negedge clk);
        chk("both.req2", bus.mem_req, 1);
        chk("both.addr2", bus.mem_addr, 32'h40);
        chk("both.we2", bus.mem_we, 0);
        chk("both.stall4", bus.stall, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h22222222;
        @(negedge clk);
        bus.mem_ready = 0;
        chk("both.ivalid", bus.if_valid, 1);
        chk("both.irdata", bus.if_rdata, 32'h22222222);
        chk("both.stall5", bus.stall, 0);
        bus.if_req = 0; bus.d_read_en = 0;
        repeat (4) begin
            @(negedge clk);
            chk("both.quiet_req", bus.mem_req, 0);
        end
        chk("both.dcount", dv_cnt - dv0, 1);
        chk("both.fcount", fv_cnt - fv0, 1);
        // reset mid-transaction, then stray mem_ready while idle
        bus.d_read_en = 1; bus.d_addr = 32'h400; bus.d_size = 2'b10;
        @(negedge clk);
        chk("rstx.req", bus.mem_req, 1);
        rst = 1;
        @(negedge clk);
        chk("rstx.req_off", bus.mem_req, 0);
        chk("rstx.addr", bus.mem_addr, 0);
        chk("rstx.be", bus.mem_be, 0);
        rst = 0; bus.d_read_en = 0;
        dv0 = dv_cnt; fv0 = fv_cnt;
        bus.mem_ready = 1; bus.mem_rdata = 32'h33333333;
        repeat (4) begin
            @(negedge clk);
            chk("rstx.quiet_req", bus.mem_req, 0);
        end
        bus.mem_ready = 0;
        chk("rstx.dcount", dv_cnt - dv0, 0);
        chk("rstx.fcount", fv_cnt - fv0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  if_req  in  1  instruction fetch request, held until served
  if_addr  in  32  fetch address, word aligned
  if_valid  out  1  one-cycle pulse, if_rdata valid
  if_rdata  out  32  fetched word
  d_read_en  in  1  LSU load request
  d_write_en  in  1  LSU store request
  d_addr  in  32  data byte address (from ALU)
  d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
  d_wdata  in  32  store data, right-aligned
  d_valid  out  1  one-cycle pulse, data access complete
  d_rdata  out  32  load data shifted to bits [7:0]/[15:0]/[31:0]
  d_err  out  1  pulses with d_valid on a misaligned access
  stall  out  1  pipeline hold
  mem_req  out  1  memory request, held until mem_ready
  mem_we  out  1  write strobe
  mem_addr  out  32  {addr[31:2],2'b00}
  mem_be  out  4  byte enables
  mem_wdata  out  32  lane-replicated write data
  mem_ready  in  1  memory completes current request this cycle
  mem_rdata  in  32  read data, valid when mem_ready=1

Function
REQ-003 The FSM SHALL have the states IDLE, DATA, FETCH, RESP_D and RESP_F, with exactly one memory transaction outstanding.
REQ-004 Pending requests SHALL be d_pend = (d_read_en|d_write_en) & !d_done and f_pend = if_req & !f_done.
REQ-005 In IDLE, d_pend SHALL take priority over f_pend: go to DATA if d_pend, else to FETCH if f_pend, else stay in IDLE.
REQ-006 On the IDLE->DATA or IDLE->FETCH transition, the block SHALL register mem_addr, mem_be, mem_wdata and mem_we, and assert mem_req from the next cycle.
REQ-007 The block SHALL hold mem_req and all mem_* outputs stable until a cycle with mem_ready=1; in that cycle it SHALL capture mem_rdata and go to RESP_D (from DATA) or RESP_F (from FETCH); mem_req SHALL be 0 in RESP_*.
REQ-008 In RESP_D, d_valid=1 and d_rdata SHALL be the captured, aligned value; in RESP_F, if_valid=1 and if_rdata SHALL be the captured word; both RESP states SHALL return to IDLE unconditionally.
REQ-009 Byte enables SHALL be: byte -> 4'b0001<<d_addr[1:0]; half -> 4'b0011<<{d_addr[1],1'b0}; word -> 4'b1111.
REQ-010 Write data SHALL be: byte -> {4{d_wdata[7:0]}}; half -> {2{d_wdata[15:0]}}; word -> d_wdata.
REQ-011 Load data SHALL be: byte -> zero-extended mem_rdata >> (8*d_addr[1:0]); half -> zero-extended mem_rdata >> (16*d_addr[1]); word -> unshifted. Sign extension is not performed here.
REQ-012 A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL go IDLE->RESP_D with no mem_req, and SHALL produce d_valid=1, d_err=1, d_rdata=0 and no memory write.
REQ-013 Fetch addresses SHALL use mem_be=4'b1111 and mem_we=0; if_addr[1:0] SHALL be ignored.
REQ-014 The block SHALL compute stall = (d_req_any & !d_done & !d_valid) | (if_req & !f_done & !if_valid), combinationally.
REQ-015 d_done SHALL set on a d_valid cycle while stall=1, and f_done SHALL set on an if_valid cycle while stall=1; both SHALL clear on any cycle with stall=0.
REQ-016 The block SHALL NOT re-serve a request already served while the pipeline is held.
REQ-017 When d_req and if_req arrive together, the data access SHALL complete first and the fetch second, with stall high until the fetch's if_valid cycle.
REQ-018 mem_ready while in IDLE or RESP_* SHALL be ignored.

Reset
REQ-019 On rst=1 the block SHALL set state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, d_err=0, if_rdata=0, d_rdata=0 and d_done=f_done=0, all in the cycle after the reset edge.
REQ-020 A reset during DATA or FETCH SHALL abandon the transaction: mem_req=0 and no valid pulse follow.
REQ-021 rst SHALL override every other input.

Verification
REQ-022 The bench SHALL cover an LW at 0x100 with mem_ready 2 cycles after mem_req and mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, d_valid one cycle with d_rdata=0xDEADBEEF, stall low in that cycle.
REQ-023 The bench SHALL cover an SB at 0x203 with d_wdata=0x000000A5 -> mem_we=1, mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-024 The bench SHALL cover an LH at 0x302 with mem_rdata=0x8001_1234 -> d_rdata=0x00008001.
REQ-025 The bench SHALL cover simultaneous if_req (0x40) and LW (0x80) -> the data transaction is issued first, then the fetch; stall=1 until if_valid; each is served exactly once.
REQ-026 The bench SHALL cover an SW at 0x105 -> no mem_req, d_valid=1 and d_err=1 in the cycle after the request.
REQ-027 The bench SHALL cover rst asserted while mem_req=1 and mem_ready=0 -> the next cycle has mem_req=0 and no d_valid/if_valid afterwards.
